// File: rtl/controlador_barramento.sv
//------------------------------------------------------------------------------
// controlador_barramento
// Bus master and sequencer for the shared tri-state data bus. Each command
// moves one word from a source (a register slice or the immediate value held
// here) into a destination slice. A guard cycle with every driver off comes
// before each drive phase, and the word seen on the bus is captured into
// DadoLido.
//
// Optional build macro: CONTADOR_TRANSFERENCIAS_EN adds the Total_Transf
// completed-transfer counter port.
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module controlador_barramento #(
  parameter int Tamanho_Da_Palavra = 16,
  parameter int Num_Regs           = 8,
  parameter int Largura_Indice     = 3
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Inicia,
  input  logic [Largura_Indice-1:0]     Origem,
  input  logic [Largura_Indice-1:0]     Destino,
  input  logic                          UsaImediato,
  input  logic [Tamanho_Da_Palavra-1:0] Imediato,
  inout  wire  [Tamanho_Da_Palavra-1:0] Data,
  output logic [Num_Regs-1:0]           Habilita_Saida,
  output logic [Num_Regs-1:0]           Carrega,
  output logic [Tamanho_Da_Palavra-1:0] DadoLido,
  output logic                          Ocupado,
  output logic                          Pronto,
  output logic                          Erro
`ifdef CONTADOR_TRANSFERENCIAS_EN
  ,
  output logic [15:0]                   Total_Transf
`endif
);

  // Single set bit at index 0; shifted by a slice index to form one-hot vectors.
  localparam logic [Num_Regs-1:0] UM = {{(Num_Regs-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    GUARDA  = 3'd1,
    DIRIGE  = 3'd2,
    CARREGA = 3'd3,
    FIM     = 3'd4
  } estado_t;

  estado_t                         estado_q;

  // Command latched on acceptance; later input changes cannot disturb it.
  logic [Largura_Indice-1:0]       origem_q;
  logic [Largura_Indice-1:0]       destino_q;
  logic                            usa_imed_q;
  logic [Tamanho_Da_Palavra-1:0]   imediato_q;

  // Registered outputs and the registered bus drive enable.
  logic                            dirige_dado_q;
  logic [Num_Regs-1:0]             habilita_q;
  logic [Num_Regs-1:0]             carrega_q;
  logic [Tamanho_Da_Palavra-1:0]   dado_lido_q;
  logic                            ocupado_q;
  logic                            pronto_q;
  logic                            erro_q;

  logic                            comando_invalido;

  // A command is rejected when it names a slice that does not exist, or when a
  // register-to-register move would read and write the same slice.
  always_comb begin
    comando_invalido = 1'b0;
    if (int'(Destino) >= Num_Regs) begin
      comando_invalido = 1'b1;
    end
    if (!UsaImediato) begin
      if (int'(Origem) >= Num_Regs) begin
        comando_invalido = 1'b1;
      end
      if (Origem == Destino) begin
        comando_invalido = 1'b1;
      end
    end
  end

`ifdef CONTADOR_TRANSFERENCIAS_EN
  logic [15:0] total_q;
  logic [15:0] total_d;

  // Next count; natural 16-bit wrap from FFFF to 0.
  always_comb begin
    total_d = total_q + 16'd1;
  end
`endif

  // Sequencer: GUARDA keeps the bus quiet, DIRIGE and CARREGA hold the source on
  // the bus, CARREGA strobes the destination, FIM reports completion.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      estado_q      <= OCIOSO;
      origem_q      <= '0;
      destino_q     <= '0;
      usa_imed_q    <= 1'b0;
      imediato_q    <= '0;
      dirige_dado_q <= 1'b0;
      habilita_q    <= '0;
      carrega_q     <= '0;
      dado_lido_q   <= '0;
      ocupado_q     <= 1'b0;
      pronto_q      <= 1'b0;
      erro_q        <= 1'b0;
`ifdef CONTADOR_TRANSFERENCIAS_EN
      total_q       <= 16'd0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
      carrega_q <= '0;

      case (estado_q)
        OCIOSO: begin
          if (Inicia) begin
            if (comando_invalido) begin
              erro_q <= 1'b1;
            end else begin
              origem_q   <= Origem;
              destino_q  <= Destino;
              usa_imed_q <= UsaImediato;
              imediato_q <= Imediato;
              ocupado_q  <= 1'b1;
              estado_q   <= GUARDA;
            end
          end
        end

        GUARDA: begin
          // Exactly one source is enabled for the drive phase.
          if (usa_imed_q) begin
            dirige_dado_q <= 1'b1;
          end else begin
            habilita_q <= UM << origem_q;
          end
          estado_q <= DIRIGE;
        end

        DIRIGE: begin
          carrega_q <= UM << destino_q;
          estado_q  <= CARREGA;
        end

        CARREGA: begin
          // The bus is still driven during this cycle, so its value is valid here.
          dado_lido_q   <= Data;
          habilita_q    <= '0;
          dirige_dado_q <= 1'b0;
          estado_q      <= FIM;
        end

        FIM: begin
          pronto_q  <= 1'b1;
          ocupado_q <= 1'b0;
`ifdef CONTADOR_TRANSFERENCIAS_EN
          total_q   <= total_d;
`endif
          estado_q  <= OCIOSO;
        end

        default: begin
          habilita_q    <= '0;
          dirige_dado_q <= 1'b0;
          ocupado_q     <= 1'b0;
          estado_q      <= OCIOSO;
        end
      endcase
    end
  end

  // Bus driven only from registered data under a registered enable.
  assign Data = dirige_dado_q ? imediato_q : {Tamanho_Da_Palavra{1'bz}};

  assign Habilita_Saida = habilita_q;
  assign Carrega        = carrega_q;
  assign DadoLido       = dado_lido_q;
  assign Ocupado        = ocupado_q;
  assign Pronto         = pronto_q;
  assign Erro           = erro_q;
`ifdef CONTADOR_TRANSFERENCIAS_EN
  assign Total_Transf   = total_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_controlador_barramento.sv
//------------------------------------------------------------------------------
// tb_controlador_barramento
// Self-checking bench: register-slice model on the bus, a cycle-offset
// reference model of each transfer, directed and random commands.
//------------------------------------------------------------------------------
`default_nettype none

module tb_controlador_barramento;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int LI = 4;   // one spare index bit so out-of-range indices can be issued

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Inicia;
  logic [LI-1:0] Origem;
  logic [LI-1:0] Destino;
  logic          UsaImediato;
  logic [W-1:0]  Imediato;
  wire  [W-1:0]  Data;
  logic [N-1:0]  Habilita_Saida;
  logic [N-1:0]  Carrega;
  logic [W-1:0]  DadoLido;
  logic          Ocupado;
  logic          Pronto;
  logic          Erro;
`ifdef CONTADOR_TRANSFERENCIAS_EN
  logic [15:0]   Total_Transf;
`endif

  controlador_barramento #(
    .Tamanho_Da_Palavra(W),
    .Num_Regs(N),
    .Largura_Indice(LI)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Inicia(Inicia),
    .Origem(Origem),
    .Destino(Destino),
    .UsaImediato(UsaImediato),
    .Imediato(Imediato),
    .Data(Data),
    .Habilita_Saida(Habilita_Saida),
    .Carrega(Carrega),
    .DadoLido(DadoLido),
    .Ocupado(Ocupado),
    .Pronto(Pronto),
    .Erro(Erro)
`ifdef CONTADOR_TRANSFERENCIAS_EN
    ,
    .Total_Transf(Total_Transf)
`endif
  );

  always #5 Clock = ~Clock;

  // ---------------- register slice environment ----------------
  logic [W-1:0] fatia [N];
  logic         ini_fatias;
  logic [W-1:0] fatia_drv;
  logic         fatia_oe;

  function automatic logic [W-1:0] valor_inicial(input int i);
    return W'((i + 1) * 16'h1357);
  endfunction

  always_comb begin
    fatia_oe  = 1'b0;
    fatia_drv = '0;
    for (int i = 0; i < N; i++) begin
      if (Habilita_Saida[i]) begin
        fatia_oe  = 1'b1;
        fatia_drv = fatia_drv | fatia[i];
      end
    end
  end

  assign Data = fatia_oe ? fatia_drv : {W{1'bz}};

  always @(posedge Clock) begin
    for (int i = 0; i < N; i++) begin
      if (ini_fatias)      fatia[i] <= valor_inicial(i);
      else if (Carrega[i]) fatia[i] <= Data;
    end
  end

  // Bus value with Z/X read as 0 so "released" compares as 0 in any simulator.
  function automatic logic [W-1:0] barramento();
    logic [W-1:0] v;
    for (int b = 0; b < W; b++) v[b] = (Data[b] === 1'b1);
    return v;
  endfunction

  // ---------------- checking ----------------
  int n_total = 0;
  int n_ok    = 0;

  task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_total++;
    if (obs === esp) n_ok++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, esp, $time);
  endtask

  // ---------------- reference model ----------------
  // fase = cycles since the accepting edge (0 = idle, 5 = completion cycle).
  int           fase;
  logic [W-1:0] ref_regs [N];
  logic         m_imm;
  int           m_src, m_dst;
  logic [W-1:0] m_val;
  logic [N-1:0] e_hab, e_car;
  logic [W-1:0] e_dl, e_bus;
  logic         e_ocup, e_pronto, e_erro;
  logic [15:0]  e_cnt;

  task automatic derivar();
    e_hab    = ((fase == 2 || fase == 3) && !m_imm) ? N'(1) << m_src : '0;
    e_car    = (fase == 3) ? N'(1) << m_dst : '0;
    e_bus    = (fase == 2 || fase == 3) ? m_val : '0;
    e_ocup   = (fase >= 1 && fase <= 4);
    e_pronto = (fase == 5);
  endtask

  // Predict the outputs after the coming rising edge from the current inputs.
  task automatic avancar();
    bit invalido;
    e_erro = 1'b0;
    if (fase == 0 || fase == 5) begin
      fase = 0;
      if (Inicia) begin
        invalido = (int'(Destino) >= N) ||
                   (!UsaImediato && (int'(Origem) >= N || Origem == Destino));
        if (invalido) e_erro = 1'b1;
        else begin
          m_imm = UsaImediato;
          m_src = int'(Origem);
          m_dst = int'(Destino);
          m_val = UsaImediato ? Imediato : ref_regs[int'(Origem)];
          fase  = 1;
        end
      end
    end else begin
      fase++;
    end
    if (fase == 4) begin
      e_dl            = m_val;
      ref_regs[m_dst] = m_val;
    end
    if (fase == 5) e_cnt = e_cnt + 16'd1;
    derivar();
  endtask

  task automatic comparar_saidas();
    verificar("habilita", 32'(Habilita_Saida), 32'(e_hab));
    verificar("carrega",  32'(Carrega),        32'(e_car));
    verificar("dadolido", 32'(DadoLido),       32'(e_dl));
    verificar("ocupado",  32'(Ocupado),        32'(e_ocup));
    verificar("pronto",   32'(Pronto),         32'(e_pronto));
    verificar("erro",     32'(Erro),           32'(e_erro));
    verificar("data",     32'(barramento()),   32'(e_bus));
    verificar("hab_onehot0", 32'($onehot0(Habilita_Saida)), 32'd1);
`ifdef CONTADOR_TRANSFERENCIAS_EN
    verificar("total", 32'(Total_Transf), 32'(e_cnt));
`endif
  endtask

  // One cycle: check the current outputs, then apply the next inputs.
  task automatic ciclo(input logic ini, input logic usa, input int o, input int d,
                       input logic [W-1:0] imm);
    @(negedge Clock);
    comparar_saidas();
    Inicia      = ini;
    UsaImediato = usa;
    Origem      = LI'(o);
    Destino     = LI'(d);
    Imediato    = imm;
    avancar();
  endtask

  initial begin
    Reset = 1'b1; ini_fatias = 1'b1;
    Inicia = 1'b0; UsaImediato = 1'b0; Origem = '0; Destino = '0; Imediato = '0;
    fase = 0; m_imm = 1'b0; m_src = 0; m_dst = 0; m_val = '0;
    e_dl = '0; e_erro = 1'b0; e_cnt = 16'd0;
    for (int i = 0; i < N; i++) ref_regs[i] = valor_inicial(i);
    derivar();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    comparar_saidas();                     // reset state
    Reset = 1'b0; ini_fatias = 1'b0;
    avancar();

    // Immediate transfer into slice 4, then idle until complete.
    ciclo(1'b1, 1'b1, 0, 4, 16'hA5C3);
    repeat (5) ciclo(1'b0, 1'b1, 0, 4, 16'h0000);
    // Register to register 1 -> 6.
    ciclo(1'b1, 1'b0, 1, 6, 16'h0000);
    repeat (5) ciclo(1'b0, 1'b0, 0, 0, 16'h0000);
    // Rejections: same slice, and destination out of range.
    ciclo(1'b1, 1'b0, 3, 3, 16'h0000);
    ciclo(1'b0, 1'b0, 0, 0, 16'h0000);
    ciclo(1'b1, 1'b1, 0, 8, 16'h1111);
    ciclo(1'b0, 1'b0, 0, 0, 16'h0000);
    // Inicia held high while inputs keep changing: back-to-back transfers.
    ciclo(1'b1, 1'b1, 0, 2, 16'h0F0F);
    for (int k = 0; k < 12; k++) ciclo(1'b1, k[0], (k % 7) + 1, 0, W'($urandom));

`ifdef CONTADOR_TRANSFERENCIAS_EN
    repeat (6) ciclo(1'b0, 1'b0, 0, 0, 16'h0000);
    @(negedge Clock);
    force dut.total_q = 16'hFFFF;
    @(posedge Clock);
    #1 release dut.total_q;
    e_cnt = 16'hFFFF;
    ciclo(1'b1, 1'b0, 3, 3, 16'h0000);      // rejected: count unchanged
    ciclo(1'b1, 1'b1, 0, 5, 16'h7777);      // completes: wraps to 0
    repeat (5) ciclo(1'b0, 1'b0, 0, 0, 16'h0000);
`endif

    // Random commands, including out-of-range indices and Origem==Destino.
    for (int k = 0; k < 300; k++) begin
      ciclo(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9), $urandom_range(0, 9), W'($urandom));
    end

    // Asynchronous reset in the middle of a drive phase from slice 2.
    repeat (6) ciclo(1'b0, 1'b0, 0, 0, 16'h0000);
    ciclo(1'b1, 1'b0, 2, 5, 16'h0000);
    ciclo(1'b0, 1'b0, 0, 0, 16'h0000);      // edge after this enters DIRIGE
    @(posedge Clock);
    #2;
    verificar("pre_reset_hab", 32'(Habilita_Saida), 32'(N'(1) << 2));
    Reset = 1'b1;
    #1;
    verificar("rst_hab",     32'(Habilita_Saida), 32'd0);
    verificar("rst_data",    32'(barramento()),   32'd0);
    verificar("rst_ocupado", 32'(Ocupado),        32'd0);
    verificar("rst_dadolido",32'(DadoLido),       32'd0);
    fase = 0; e_dl = '0; e_erro = 1'b0; e_cnt = 16'd0;
    derivar();
    @(negedge Clock);
    Reset = 1'b0;
    Inicia = 1'b0;
    avancar();
    ciclo(1'b1, 1'b1, 0, 4, 16'h5A5A);
    repeat (6) ciclo(1'b0, 1'b0, 0, 0, 16'h0000);

    $display("%0d/%0d checks passed", n_ok, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/controlador_barramento.md
Name: controlador_barramento

Overview:
- Bus master and sequencer for the shared bidirectional data bus that the processor's tri-state register slices sit on.
- Executes one transfer per command: a source drives the bus, and a destination is strobed to load it. The source is either a register slice or an immediate value from this block.
- Owns the turnaround guard cycle, so at most one driver is enabled at any edge. Also captures the bus value for the control unit.

Parameters:
- Tamanho_Da_Palavra, 16, bus / data word width in bits.
- Num_Regs, 8, number of register slices on the bus.
- Largura_Indice, 3, width of the register index; must satisfy 2**Largura_Indice >= Num_Regs.

Ports:
- Clock  input  1  single system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Inicia  input  1  start request; sampled only while in OCIOSO.
- Origem  input  Largura_Indice  source register index; ignored when UsaImediato=1.
- Destino  input  Largura_Indice  destination register index.
- UsaImediato  input  1  1 means this block drives Imediato onto the bus as the source.
- Imediato  input  Tamanho_Da_Palavra  immediate value.
- Data  inout  Tamanho_Da_Palavra  shared tri-state bus; high-Z unless this block is the source.
- Habilita_Saida  output  Num_Regs  one-hot drive enable to the register slices.
- Carrega  output  Num_Regs  one-hot, one-cycle load strobe to the register slices.
- DadoLido  output  Tamanho_Da_Palavra  bus value captured on the last successful transfer.
- Ocupado  output  1  high from acceptance until return to OCIOSO.
- Pronto  output  1  one-cycle completion pulse.
- Erro  output  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - Habilita_Saida=0, Carrega=0, Data released to Z.
  - DadoLido=0, Ocupado=0, Pronto=0, Erro=0, state=OCIOSO.
- All outputs are registered. Data is driven from a registered value and a registered enable.
- Command latch: on the accepting edge, Origem, Destino, UsaImediato and Imediato are registered. Later input changes have no effect on the transfer in progress.
- FSM states: OCIOSO, GUARDA, DIRIGE, CARREGA, FIM.
  - OCIOSO:
    - Inicia=1 with a valid command -> latch the command, Ocupado=1, go to GUARDA.
    - Inicia=1 with an invalid command -> Erro pulses for 1 cycle, no bus activity, stay in OCIOSO.
    - Invalid means Destino >= Num_Regs; or UsaImediato=0 and Origem >= Num_Regs; or UsaImediato=0 and Origem==Destino.
  - GUARDA: turnaround cycle with every driver off and the bus Z. Go to DIRIGE.
  - DIRIGE:
    - UsaImediato=0: Habilita_Saida[Origem]=1.
    - UsaImediato=1: Data=Imediato.
    - Go to CARREGA.
  - CARREGA: the source keeps driving and Carrega[Destino]=1 for exactly this cycle. At the end of this cycle, DadoLido <= Data. Go to FIM.
  - FIM: all drivers off, Carrega=0, Pronto=1 for 1 cycle, Ocupado=0. Go to OCIOSO.
- Latency: with Inicia accepted at edge k, Pronto is high in the cycle after edge k+4. The next Inicia can be accepted at edge k+5, so back-to-back issue gives one transfer per 5 cycles.
- Inicia while Ocupado=1: ignored, not queued, no Erro.
- At most one bit of Habilita_Saida is ever set. Habilita_Saida is never set while this block drives Data.
- Data is never driven outside DIRIGE/CARREGA.

Optional Feature:
- Macro CONTADOR_TRANSFERENCIAS_EN.
- Defined:
  - Adds output Total_Transf (16 bits), reset to 0.
  - Increments by 1 on each Pronto pulse and wraps from 16'hFFFF to 0.
  - Erro pulses do not count.
- Undefined: the port and the counter do not exist. All other behaviour is identical.

Test Plan:
- Reset asserted mid-DIRIGE with Origem=2 -> Habilita_Saida=0 and Data=Z in the same cycle without waiting for an edge; after release, state OCIOSO, DadoLido=0.
- Immediate transfer: UsaImediato=1, Imediato=16'hA5C3, Destino=4, Inicia pulse -> GUARDA with Data Z; Data=16'hA5C3 for 2 cycles; Carrega=8'b0001_0000 for exactly 1 cycle; DadoLido=16'hA5C3; Pronto 4 cycles after acceptance.
- Register-to-register: a slice model holds 16'h1234 at index 1, Origem=1, Destino=6 -> Habilita_Saida=8'b0000_0010 for 2 cycles, Carrega[6] pulses, DadoLido=16'h1234; the assertion "no two drivers enabled" holds on every cycle.
- Rejections, each -> Erro pulses once, Ocupado stays 0, Data stays Z:
  - Origem=3, Destino=3, UsaImediato=0.
  - Destino=8 with Num_Regs=8.
- Inicia held high across a transfer, with Origem/Imediato changed mid-transfer -> the original command completes unchanged, then a second transfer starts at the edge after FIM (5-cycle spacing).
- With CONTADOR_TRANSFERENCIAS_EN, preload the counter to 16'hFFFF by forcing or running transfers -> one more transfer gives Total_Transf=0; an Erro-only command leaves the count unchanged.
